// File: rtl/instr_decode_pkg.sv
// Shared MIPS decode definitions: FSM command codes, opcode and funct
// constants, and the immediate-formatting helper used by the decoder.
package instr_decode_pkg;

    // Command codes consumed by the control FSM. The gap 12..14 is unused.
    // CMD_ILL marks any encoding the core does not implement.
    typedef enum logic [3:0] {
        CMD_LW   = 4'd0,
        CMD_SW   = 4'd1,
        CMD_J    = 4'd2,
        CMD_JR   = 4'd3,
        CMD_JAL  = 4'd4,
        CMD_BEQ  = 4'd5,
        CMD_BNE  = 4'd6,
        CMD_XORI = 4'd7,
        CMD_ADDI = 4'd8,
        CMD_ADD  = 4'd9,
        CMD_SUB  = 4'd10,
        CMD_SLT  = 4'd11,
        CMD_ILL  = 4'd15
    } cmd_t;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Link register written by JAL
    localparam logic [4:0] RA_REG = 5'd31;

    // Sign-extend a 16-bit immediate to a 32-bit datapath word
    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Word-offset form of an immediate: sign-extended, then scaled by 4
    function automatic logic [31:0] sign_ext16_x4(input logic [15:0] imm);
        logic [31:0] ext;
        ext = sign_ext16(imm);
        return {ext[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/instr_decode_opcode_map.sv
// Pure combinational map from opcode/funct to the FSM command code.
// Any encoding not listed decodes as CMD_ILL, including R-type funct 0
// (so the all-zero word is illegal). shamt and other fields never matter.
module opcode_map
    import instr_decode_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cmd_t       cmd
);

    // R-type sub-decode on funct, kept separate so the main case stays flat
    cmd_t rtype_cmd;

    // Resolve the funct field for opcode 0
    always_comb begin
        rtype_cmd = CMD_ILL;
        case (funct)
            FN_JR:   rtype_cmd = CMD_JR;
            FN_ADD:  rtype_cmd = CMD_ADD;
            FN_SUB:  rtype_cmd = CMD_SUB;
            FN_SLT:  rtype_cmd = CMD_SLT;
            default: rtype_cmd = CMD_ILL;
        endcase
    end

    // Primary opcode decode
    always_comb begin
        cmd = CMD_ILL;
        case (opcode)
            OP_RTYPE: cmd = rtype_cmd;
            OP_LW:    cmd = CMD_LW;
            OP_SW:    cmd = CMD_SW;
            OP_J:     cmd = CMD_J;
            OP_JAL:   cmd = CMD_JAL;
            OP_BEQ:   cmd = CMD_BEQ;
            OP_BNE:   cmd = CMD_BNE;
            OP_XORI:  cmd = CMD_XORI;
            OP_ADDI:  cmd = CMD_ADDI;
            default:  cmd = CMD_ILL;
        endcase
    end

endmodule

// File: rtl/instr_decode.sv
// Instruction register plus registered decoder for the multicycle core.
// On irWe the memory word is captured and, on the same edge, the command
// code, register specifiers and formatted immediates are registered from
// the incoming word, so every output agrees with ir the cycle after a load.
// Unsupported captures set a sticky flag and bump a saturating counter.
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 irWe,
    input  logic [31:0]          instr,
    output logic [31:0]          ir,
    output logic [3:0]           cmd,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [31:0]          sxi,
    output logic [31:0]          sxis,
    output logic [27:0]          jTarget,
    output logic                 valid,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegalCount
);

    localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

    // Decode of the incoming word (not the held ir)
    cmd_t        cmd_next;
    logic [4:0]  rd_next;
    logic [31:0] sxi_next;
    logic [31:0] sxis_next;
    logic [27:0] jtarget_next;
    logic        is_ill_next;

    // Registered state
    logic [31:0]          ir_reg;
    cmd_t                 cmd_reg;
    logic [4:0]           rs_reg;
    logic [4:0]           rt_reg;
    logic [4:0]           rd_reg;
    logic [31:0]          sxi_reg;
    logic [31:0]          sxis_reg;
    logic [27:0]          jtarget_reg;
    logic                 valid_reg;
    logic                 illegal_reg;
    logic [ILL_CNT_W-1:0] ill_cnt_reg;

    opcode_map u_opcode_map (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .cmd    (cmd_next)
    );

    // Datapath-facing fields derived from the incoming word; JAL links into $ra
    always_comb begin
        rd_next      = (cmd_next == CMD_JAL) ? RA_REG : instr[15:11];
        sxi_next     = sign_ext16(instr[15:0]);
        sxis_next    = sign_ext16_x4(instr[15:0]);
        jtarget_next = {instr[25:0], 2'b00};
        is_ill_next  = (cmd_next == CMD_ILL);
    end

    // Instruction register and decoded fields: load together, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_reg      <= '0;
            cmd_reg     <= CMD_ILL;
            rs_reg      <= '0;
            rt_reg      <= '0;
            rd_reg      <= '0;
            sxi_reg     <= '0;
            sxis_reg    <= '0;
            jtarget_reg <= '0;
            valid_reg   <= 1'b0;
        end else if (irWe) begin
            ir_reg      <= instr;
            cmd_reg     <= cmd_next;
            rs_reg      <= instr[25:21];
            rt_reg      <= instr[20:16];
            rd_reg      <= rd_next;
            sxi_reg     <= sxi_next;
            sxis_reg    <= sxis_next;
            jtarget_reg <= jtarget_next;
            valid_reg   <= 1'b1;
        end
    end

    // Sticky illegal flag and saturating count; only reset clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_reg <= 1'b0;
            ill_cnt_reg <= '0;
        end else if (irWe && is_ill_next) begin
            illegal_reg <= 1'b1;
            if (!(&ill_cnt_reg)) begin
                ill_cnt_reg <= ill_cnt_reg + CNT_ONE;
            end
        end
    end

    assign ir           = ir_reg;
    assign cmd          = cmd_reg;
    assign rs           = rs_reg;
    assign rt           = rt_reg;
    assign rd           = rd_reg;
    assign sxi          = sxi_reg;
    assign sxis         = sxis_reg;
    assign jTarget      = jtarget_reg;
    assign valid        = valid_reg;
    assign illegal      = illegal_reg;
    assign illegalCount = ill_cnt_reg;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: a table-driven reference model is
// compared against the DUT on every falling edge, plus hand-computed
// literal checks from the directed program.
module tb_instr_decode;

    logic        clk;
    logic        rst;
    logic        irWe;
    logic [31:0] instr;
    logic [31:0] ir;
    logic [3:0]  cmd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sxi;
    logic [31:0] sxis;
    logic [27:0] jTarget;
    logic        valid;
    logic        illegal;
    logic [7:0]  illegalCount;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    instr_decode #(.ILL_CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .irWe         (irWe),
        .instr        (instr),
        .ir           (ir),
        .cmd          (cmd),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .sxi          (sxi),
        .sxis         (sxis),
        .jTarget      (jTarget),
        .valid        (valid),
        .illegal      (illegal),
        .illegalCount (illegalCount)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int op_tab[64];
    int fn_tab[64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            op_tab[i] = 15;
            fn_tab[i] = 15;
        end
        op_tab['h23] = 0;  op_tab['h2B] = 1;  op_tab['h02] = 2;  op_tab['h03] = 4;
        op_tab['h04] = 5;  op_tab['h05] = 6;  op_tab['h0E] = 7;  op_tab['h08] = 8;
        op_tab['h00] = -1; // resolved by funct
        fn_tab['h08] = 3;  fn_tab['h20] = 9;  fn_tab['h22] = 10; fn_tab['h2A] = 11;
    end

    function automatic int model_cmd(input logic [31:0] w);
        int c;
        c = op_tab[int'(w[31:26])];
        if (c < 0) c = fn_tab[int'(w[5:0])];
        return c;
    endfunction

    logic [31:0] m_ir;
    int          m_cmd;
    int          m_rs, m_rt, m_rd;
    logic [31:0] m_sxi, m_sxis;
    logic [27:0] m_jt;
    int          m_valid, m_illegal, m_cnt;

    // Model state update, following the same async-reset/load rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ir <= 0; m_cmd <= 15; m_rs <= 0; m_rt <= 0; m_rd <= 0;
            m_sxi <= 0; m_sxis <= 0; m_jt <= 0;
            m_valid <= 0; m_illegal <= 0; m_cnt <= 0;
        end else if (irWe) begin
            int c;
            int imm;
            c = model_cmd(instr);
            imm = int'(instr[15:0]);
            if (imm >= 32768) imm = imm - 65536;
            m_ir    <= instr;
            m_cmd   <= c;
            m_rs    <= int'(instr[25:21]);
            m_rt    <= int'(instr[20:16]);
            m_rd    <= (c == 4) ? 31 : int'(instr[15:11]);
            m_sxi   <= 32'(imm);
            m_sxis  <= 32'(imm * 4);
            m_jt    <= 28'(int'(instr[25:0]) * 4);
            m_valid <= 1;
            if (c == 15) begin
                m_illegal <= 1;
                m_cnt     <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge once checking is enabled
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_ir",      ir,                   m_ir);
            chk("m_cmd",     32'(cmd),             32'(m_cmd));
            chk("m_rs",      32'(rs),              32'(m_rs));
            chk("m_rt",      32'(rt),              32'(m_rt));
            chk("m_rd",      32'(rd),              32'(m_rd));
            chk("m_sxi",     sxi,                  m_sxi);
            chk("m_sxis",    sxis,                 m_sxis);
            chk("m_jt",      32'(jTarget),         32'(m_jt));
            chk("m_valid",   32'(valid),           32'(m_valid));
            chk("m_illegal", 32'(illegal),         32'(m_illegal));
            chk("m_cnt",     32'(illegalCount),    32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    // One capture: irWe high across exactly one rising edge
    task automatic load(input logic [31:0] w);
        @(negedge clk);
        irWe  = 1;
        instr = w;
        @(negedge clk);
        irWe  = 0;
        #1;
        $display("load 0x%08h -> cmd=%0d rs=%0d rt=%0d rd=%0d sxi=0x%08h ill=%0b cnt=%0d",
                 w, cmd, rs, rt, rd, sxi, illegal, illegalCount);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ir"},    ir,                 32'h0);
        chk({tag, "_cmd"},   32'(cmd),           32'd15);
        chk({tag, "_rd"},    32'(rd),            32'd0);
        chk({tag, "_sxi"},   sxi,                32'h0);
        chk({tag, "_jt"},    32'(jTarget),       32'h0);
        chk({tag, "_valid"}, 32'(valid),         32'd0);
        chk({tag, "_ill"},   32'(illegal),       32'd0);
        chk({tag, "_cnt"},   32'(illegalCount),  32'd0);
    endtask

    logic [31:0] misc_prog [8] = '{
        32'hAC0A0008,  // sw   -> 1
        32'h08000100,  // j    -> 2
        32'h1109FFFE,  // beq  -> 5
        32'h15090003,  // bne  -> 6
        32'h390B00FF,  // xori -> 7
        32'h01095022,  // sub  -> 10
        32'h0109502A,  // slt  -> 11
        32'h01095160   // add with shamt=5 -> 9
    };
    int misc_cmd [8] = '{1, 2, 5, 6, 7, 10, 11, 9};

    initial begin
        rst   = 0;
        irWe  = 0;
        instr = 32'h20080005;
        #1 rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        check_en = 1;

        // Idle after reset: nothing captured despite instr on the bus
        repeat (5) @(negedge clk);
        #1;
        chk_reset_vals("idle");

        // addi $t0,$0,5
        load(32'h20080005);
        chk("addi_cmd",  32'(cmd), 32'd8);
        chk("addi_rt",   32'(rt),  32'd8);
        chk("addi_sxi",  sxi,      32'h00000005);
        chk("addi_sxis", sxis,     32'h00000014);
        chk("addi_valid", 32'(valid), 32'd1);
        instr = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        #1;
        chk("hold_ir",  ir,        32'h20080005);
        chk("hold_cmd", 32'(cmd),  32'd8);

        // lw $t1,-4($0)
        load(32'h8C09FFFC);
        chk("lw_cmd",  32'(cmd), 32'd0);
        chk("lw_rt",   32'(rt),  32'd9);
        chk("lw_sxi",  sxi,      32'hFFFFFFFC);
        chk("lw_sxis", sxis,     32'hFFFFFFF0);

        // add $t2,$t0,$t1
        load(32'h01095020);
        chk("add_cmd", 32'(cmd), 32'd9);
        chk("add_rs",  32'(rs),  32'd8);
        chk("add_rd",  32'(rd),  32'd10);

        // jal 0x40
        load(32'h0C000010);
        chk("jal_cmd", 32'(cmd),     32'd4);
        chk("jal_rd",  32'(rd),      32'd31);
        chk("jal_jt",  32'(jTarget), 32'h00000040);

        // jr $ra
        load(32'h03E00008);
        chk("jr_cmd", 32'(cmd), 32'd3);
        chk("jr_rs",  32'(rs),  32'd31);
        chk("no_ill_yet", 32'(illegal), 32'd0);

        // Remaining opcodes/functs
        for (int i = 0; i < 8; i++) begin
            load(misc_prog[i]);
            chk($sformatf("misc%0d_cmd", i), 32'(cmd), 32'(misc_cmd[i]));
        end

        // All-zero word is illegal
        load(32'h00000000);
        chk("zero_cmd", 32'(cmd),          32'd15);
        chk("zero_ill", 32'(illegal),      32'd1);
        chk("zero_cnt", 32'(illegalCount), 32'd1);

        // 300 back-to-back illegal captures, a mix of bad opcodes and functs
        @(negedge clk);
        irWe = 1;
        for (int i = 0; i < 300; i++) begin
            case (i % 3)
                0:       instr = 32'hFC000000 | 32'(i);    // opcode 0x3F
                1:       instr = 32'h01095021;             // funct 0x21
                default: instr = 32'h00000000;
            endcase
            @(negedge clk);
        end
        irWe = 0;
        #1;
        $display("burst of 300 illegal loads -> cnt=%0d", illegalCount);
        chk("sat_cnt", 32'(illegalCount), 32'd255);
        repeat (2) @(negedge clk);

        // Legal load after saturation leaves sticky state untouched
        load(32'h20080005);
        chk("post_sat_cmd", 32'(cmd),          32'd8);
        chk("post_sat_ill", 32'(illegal),      32'd1);
        chk("post_sat_cnt", 32'(illegalCount), 32'd255);

        // Asynchronous reset between edges clears everything immediately
        load(32'h8C09FFFC);
        #2 rst = 1;
        #1;
        $display("async rst mid-cycle -> cmd=%0d valid=%0b cnt=%0d", cmd, valid, illegalCount);
        chk_reset_vals("async");
        @(negedge clk);
        rst = 0;

        // Load, then rst and irWe together across an edge: reset wins
        load(32'h01095020);
        @(negedge clk);
        irWe  = 1;
        instr = 32'h0C000010;
        rst   = 1;
        @(negedge clk);
        #1;
        $display("rst+irWe at edge -> cmd=%0d valid=%0b ir=0x%08h", cmd, valid, ir);
        chk_reset_vals("rst_win");
        irWe = 0;
        rst  = 0;
        repeat (2) @(negedge clk);

        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
